fact_bcd_conv: RTL and testbench

- Downstream stage of the factorial unit. Takes the finished 32-bit factorial result and converts it to packed BCD for the decimal display path.
- Uses serial shift-and-add-3 (double dabble): one input bit per clock.
- Upstream glue raises in_valid when the factorial's ready rises with a fresh result. The display/readout logic consumes out_bcd through a valid/ready handshake.

---
 rtl/fact_pkg.sv | 17 +
 rtl/fact_bcd_conv_add3.sv | 11 +
 rtl/fact_bcd_conv.sv | 131 +++++++++++++
 tb/tb_fact_bcd_conv.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial unit and its BCD readout stage.
package fact_pkg;

    localparam int unsigned FACT_W     = 32;
    localparam int unsigned BCD_DIGITS = 10;
    localparam logic [3:0]  BCD_BLANK  = 4'hF;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

    typedef logic [4*BCD_DIGITS-1:0] bcd_word_t;

    // ceil(w * log10(2)) in integer arithmetic (0.30103 scaled by 1e5)
    function automatic int unsigned min_bcd_digits(input int unsigned w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/fact_bcd_conv_add3.sv
// Per-digit double-dabble correction: digits of 5 or more get +3 before the shift.
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] fixed
);

    always_comb begin
        fixed = (digit >= 4'd5) ? digit + 4'd3 : digit;
    end

endmodule

// File: rtl/fact_bcd_conv.sv
// Serial binary-to-packed-BCD converter (shift-and-add-3), one input bit per clock.
// Optional: define FACT_BCD_BLANK_EN to blank leading zero digits of out_bcd with 4'hF.
module fact_bcd_conv
    import fact_pkg::*;
#(
    parameter int unsigned WIDTH  = FACT_W,
    parameter int unsigned DIGITS = BCD_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  busy
);

    localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    if (DIGITS < min_bcd_digits(WIDTH)) begin : g_digits_check
        $error("fact_bcd_conv: DIGITS too small to hold 2**WIDTH-1");
    end

    bcd_state_t state, state_next;

    logic [WIDTH-1:0]    bin_sr;
    logic [4*DIGITS-1:0] bcd_sr;
    logic [CNT_W-1:0]    cnt;
    logic [4*DIGITS-1:0] out_reg;

    logic [4*DIGITS-1:0] corrected;
    logic [4*DIGITS-1:0] bcd_shifted;
    logic [WIDTH-1:0]    bin_shifted;
    logic [4*DIGITS-1:0] result_disp;
    logic                load;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3 u_add3 (
            .digit (bcd_sr[4*g +: 4]),
            .fixed (corrected[4*g +: 4])
        );
    end

    // {bcd_sr, bin_sr} shifted left by one after digit correction
    assign bcd_shifted = {corrected[4*DIGITS-2:0], bin_sr[WIDTH-1]};
    assign bin_shifted = bin_sr << 1;

`ifdef FACT_BCD_BLANK_EN
    logic leading;

    // Digit 0 is never blanked so a zero result still shows a single 0.
    always_comb begin
        result_disp = bcd_shifted;
        leading     = 1'b1;
        for (int unsigned i = DIGITS - 1; i > 0; i--) begin
            if (leading && (bcd_shifted[4*i +: 4] == 4'd0)) begin
                result_disp[4*i +: 4] = BCD_BLANK;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign result_disp = bcd_shifted;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr  <= '0;
            bcd_sr  <= '0;
            cnt     <= '0;
            out_reg <= '0;
        end else if (load) begin
            bin_sr <= in_bin;
            bcd_sr <= '0;
            cnt    <= CNT_LAST;
        end else if (busy) begin
            bin_sr <= bin_shifted;
            bcd_sr <= bcd_shifted;
            if (cnt == '0) begin
                out_reg <= result_disp;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign out_bcd = out_reg;

endmodule

// File: tb/tb_fact_bcd_conv.sv
// Directed self-checking bench for fact_bcd_conv (default parameters).
module tb_fact_bcd_conv;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_bin    = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [39:0] out_bcd;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

`ifdef FACT_BCD_BLANK_EN
    localparam logic [39:0] E_12  = 40'hF479001600;
    localparam logic [39:0] E_0   = 40'hFFFFFFFFF0;
    localparam logic [39:0] E_MAX = 40'h4294967295;
    localparam logic [39:0] E_10  = 40'hFFF3628800;
    localparam logic [39:0] E_720 = 40'hFFFFFFF720;
    localparam logic [39:0] E_120 = 40'hFFFFFFF120;
`else
    localparam logic [39:0] E_12  = 40'h0479001600;
    localparam logic [39:0] E_0   = 40'h0000000000;
    localparam logic [39:0] E_MAX = 40'h4294967295;
    localparam logic [39:0] E_10  = 40'h0003628800;
    localparam logic [39:0] E_720 = 40'h0000000720;
    localparam logic [39:0] E_120 = 40'h0000000120;
`endif

    fact_bcd_conv #(.WIDTH(32), .DIGITS(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Transfer one value, then expect out_valid exactly WIDTH edges after the transfer edge.
    task automatic convert(input string tag, input logic [31:0] value,
                           input logic [39:0] exp, input bit scramble);
        int unsigned w;
        w = 0;
        while (!in_ready && w < 10) begin
            tick();
            w++;
        end
        check({tag, " in_ready before load"}, {39'b0, in_ready}, 40'd1);
        in_bin    = value;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check({tag, " busy after load"}, {39'b0, busy}, 40'd1);
        check({tag, " in_ready after load"}, {39'b0, in_ready}, 40'd0);
        for (int k = 1; k < 32; k++) begin
            if (scramble) in_bin = $urandom;
            tick();
        end
        check({tag, " out_valid one early"}, {39'b0, out_valid}, 40'd0);
        tick();
        check({tag, " out_valid on time"}, {39'b0, out_valid}, 40'd1);
        check({tag, " busy in done"}, {39'b0, busy}, 40'd0);
        check({tag, " out_bcd"}, out_bcd, exp);
    endtask

    task automatic drain(input string tag, input logic [39:0] exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid after drain"}, {39'b0, out_valid}, 40'd0);
        check({tag, " in_ready after drain"}, {39'b0, in_ready}, 40'd1);
        check({tag, " out_bcd held after drain"}, out_bcd, exp);
    endtask

    initial begin
        #12;
        check("reset in_ready", {39'b0, in_ready}, 40'd1);
        check("reset out_valid", {39'b0, out_valid}, 40'd0);
        check("reset busy", {39'b0, busy}, 40'd0);
        check("reset out_bcd", out_bcd, 40'd0);
        rst_n = 1'b1;
        tick();

        convert("12!", 32'd479001600, E_12, 1'b0);
        // back-pressure: hold result, ignore in_valid pulses
        for (int i = 0; i < 20; i++) begin
            in_valid = i[0];
            in_bin   = 32'd5;
            tick();
            check("bp out_valid", {39'b0, out_valid}, 40'd1);
            check("bp out_bcd", out_bcd, E_12);
            check("bp in_ready", {39'b0, in_ready}, 40'd0);
        end
        in_valid = 1'b0;
        drain("12!", E_12);
        tick();
        check("no queued load busy", {39'b0, busy}, 40'd0);

        convert("zero", 32'd0, E_0, 1'b0);
        drain("zero", E_0);

        convert("max", 32'hFFFF_FFFF, E_MAX, 1'b0);
        drain("max", E_MAX);

        convert("10! scrambled", 32'd3628800, E_10, 1'b1);
        drain("10! scrambled", E_10);

        // asynchronous reset mid-conversion
        in_bin   = 32'd40320;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        check("pre-reset busy", {39'b0, busy}, 40'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", {39'b0, out_valid}, 40'd0);
        check("async rst busy", {39'b0, busy}, 40'd0);
        check("async rst out_bcd", out_bcd, 40'd0);
        check("async rst in_ready", {39'b0, in_ready}, 40'd1);
        #2;
        rst_n = 1'b1;
        tick();

        convert("720", 32'd720, E_720, 1'b0);
        drain("720", E_720);

        convert("120", 32'd120, E_120, 1'b0);
        drain("120", E_120);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
